rf_wb_arbiter: RTL
==================

RF_WB_ARBITER -- requirements
Module: rf_wb_arbiter

Interface
REQ-001 Parameters SHALL be:
- NUM_REQ, 3, number of write-back requesters (2..4)
- AW, 3, register address width
- DW, 64, register data width
REQ-002 Clock SHALL be clk; reset SHALL be reset, synchronous, active-high.
REQ-003 Ports SHALL be:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- req_valid  in  NUM_REQ  per-requester write request
- req_addr  in  NUM_REQ*AW  per-requester destination register, requester i at slice i
- req_data  in  NUM_REQ*DW  per-requester write data
- req_ready  out  NUM_REQ  per-requester grant/accept
- rf_wena  out  1  register-file write enable
- rf_waddr  out  AW  register-file write address
- rf_wdata  out  DW  register-file write data
- rf_busy  out  2**AW  one-hot mask of the register being written this cycle
- stall_cnt  out  NUM_REQ*16  per-requester saturating stall counters (macro-gated, REQ-020)

Function
REQ-004 Arbiter SHALL share the register file's single write port among NUM_REQ requesters, granting at most one per cycle.
REQ-005 A request transfers when req_valid[i] and req_ready[i] are both high on a rising clk edge.
REQ-006 req_ready SHALL be combinational from req_valid and the priority pointer, and is one-hot or zero.
REQ-007 req_ready[i] SHALL never be high while req_valid[i] is low.
REQ-008 Requesters SHALL hold req_valid, req_addr and req_data stable until accepted; the arbiter relies on this and does not latch unaccepted requests.
REQ-009 Arbitration SHALL be round-robin:
- The search starts at pointer ptr (0..NUM_REQ-1) and ascends modulo NUM_REQ.
- The first valid requester found is granted.
REQ-010 On a grant to requester g, ptr SHALL update to (g+1) mod NUM_REQ at the next edge; with no grant, ptr holds.
REQ-011 Output stage SHALL be registered, with a latency of 1 cycle from acceptance to the rf_* outputs:
- rf_wena <= |grant.
- rf_waddr and rf_wdata <= the granted requester's addr/data.
- rf_waddr and rf_wdata hold their previous value when there is no grant.
REQ-012 rf_busy SHALL equal (1 << rf_waddr) when rf_wena=1, and all zeros otherwise.
REQ-013 Simultaneous requests to the same address SHALL be serialised in round-robin order; the last-granted data ends in the register file and no merging occurs.
REQ-014 Back-to-back grants SHALL sustain one write per cycle with no bubble.
REQ-015 A single continuously valid requester SHALL be granted every cycle.

Reset
REQ-016 While reset=1, all outputs SHALL be driven to their reset values:
- req_ready=0, rf_wena=0, rf_waddr=0, rf_wdata=0, rf_busy=0.
- ptr=0 and all stall_cnt=0.
REQ-017 Reset asserted while a write is in the output stage SHALL drop that write, so rf_wena is 0 in the following cycle.
REQ-018 No request is accepted in any cycle where reset=1.
REQ-019 Reset SHALL take priority over all other updates in the same cycle.

Configuration
REQ-020 Macro RF_WB_STALL_CNT_EN SHALL gate the stall counters.
- Defined: stall_cnt[i] increments by 1 on each cycle with req_valid[i]=1 and req_ready[i]=0, and saturates at 16'hFFFF.
- Defined: stall_cnt[i] clears on reset only.
- Undefined: stall_cnt is tied to all zeros and no counter flops exist.

Structure
REQ-021 A shared package SHALL hold the AW/DW defaults, the NUM_REQ default, and the stall-counter width constant (16).
REQ-022 Round-robin grant logic SHALL be a sub-module rr_arbiter (inputs req vector and ptr; outputs one-hot grant and granted index), instantiated once.
REQ-023 The block SHALL connect to the register file's waddr/wdata/wena ports without glue logic.

Verification
REQ-024 Single requester: req_valid=001, req_addr0=5, req_data0=64'hDEAD_BEEF, held 1 cycle -> req_ready=001 that cycle; next cycle rf_wena=1, rf_waddr=5, rf_wdata=64'hDEAD_BEEF, rf_busy=8'h20.
REQ-025 Fairness: all three valid continuously for 6 cycles from reset (ptr=0) -> grants 0,1,2,0,1,2; each requester's data appears on rf_wdata exactly twice, in that order.
REQ-026 Same-address collision: req0 and req2 both target register 3 with data 1 and 2, ptr=2 -> req2 granted first, req0 second; rf_wdata sequence is 2 then 1.
REQ-027 Reset mid-operation: grant req1 at cycle N, assert reset at N+1 -> rf_wena=0 at N+2, ptr=0, req_ready=0 during reset.
REQ-028 Stall counters (RF_WB_STALL_CNT_EN defined): req0 and req1 valid for 10 cycles from ptr=0 -> stall_cnt0=5, stall_cnt1=5.
REQ-029 Stall counters (RF_WB_STALL_CNT_EN undefined): same stimulus as REQ-028 -> stall_cnt reads all zeros.

Source files
------------

// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
// Holds the default requester count, address/data widths and the
// stall-counter width.
package rf_wb_arbiter_pkg;

  localparam int NUM_REQ_DEF = 3;
  localparam int AW_DEF      = 3;
  localparam int DW_DEF      = 64;
  localparam int STALL_CW    = 16;

  // Index width for a pointer over n requesters (at least one bit).
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rf_wb_arbiter_rr.sv
// Round-robin grant logic: the search starts at ptr and ascends modulo N.
// The first valid requester found is granted, producing a one-hot grant,
// the granted index, and an any-grant flag.
module rr_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int N  = NUM_REQ_DEF,
  parameter int IW = idx_width(NUM_REQ_DEF)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx,
  output logic          any
);

  int k;

  // Walk the requesters starting at ptr and pick the first valid one.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int off = 0; off < N; off++) begin
      k = (int'(ptr) + off) % N;
      if (!any && req[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = IW'(k);
      end
    end
  end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Shares the register file's single write port among NUM_REQ requesters.
// A round-robin grant is issued each cycle, and the winner's addr/data are
// registered onto the rf_* port with a latency of one cycle.
// Optional macro RF_WB_STALL_CNT_EN adds per-requester saturating stall
// counters; without it, stall_cnt is tied to zero.
module rf_wb_arbiter
  import rf_wb_arbiter_pkg::*;
#(
  parameter int NUM_REQ = NUM_REQ_DEF,
  parameter int AW      = AW_DEF,
  parameter int DW      = DW_DEF
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*AW-1:0]        req_addr,
  input  logic [NUM_REQ*DW-1:0]        req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         rf_wena,
  output logic [AW-1:0]                rf_waddr,
  output logic [DW-1:0]                rf_wdata,
  output logic [2**AW-1:0]             rf_busy,
  output logic [NUM_REQ*STALL_CW-1:0]  stall_cnt
);

  localparam int IW = idx_width(NUM_REQ);

  logic [IW-1:0]      ptr_reg;
  logic [IW-1:0]      ptr_next;
  logic [NUM_REQ-1:0] req_masked;
  logic [NUM_REQ-1:0] grant;
  logic [IW-1:0]      grant_idx;
  logic               grant_any;

  // No request may be accepted while reset is high.
  assign req_masked = reset ? '0 : req_valid;

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_rr (
    .req   (req_masked),
    .ptr   (ptr_reg),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  assign req_ready = grant;

  // Pointer moves one past the winner; it holds when nobody is granted.
  always_comb begin
    ptr_next = ptr_reg;
    if (grant_any) begin
      ptr_next = (grant_idx == IW'(NUM_REQ - 1)) ? '0 : grant_idx + IW'(1);
    end
  end

  // Priority pointer register.
  always_ff @(posedge clk) begin
    if (reset) ptr_reg <= '0;
    else       ptr_reg <= ptr_next;
  end

  // Registered write port; address/data hold when there is no grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_wena  <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      rf_wena <= grant_any;
      if (grant_any) begin
        rf_waddr <= req_addr[grant_idx*AW +: AW];
        rf_wdata <= req_data[grant_idx*DW +: DW];
      end
    end
  end

  // One-hot mask of the register being written this cycle.
  for (genvar gi = 0; gi < 2**AW; gi++) begin : g_busy
    assign rf_busy[gi] = rf_wena && (rf_waddr == AW'(gi));
  end

`ifdef RF_WB_STALL_CNT_EN
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_stall
    logic [STALL_CW-1:0] cnt_reg;
    // Count cycles where this requester waits; saturate at all ones.
    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (req_valid[gi] && !grant[gi] && (cnt_reg != {STALL_CW{1'b1}})) begin
        cnt_reg <= cnt_reg + STALL_CW'(1);
      end
    end
    assign stall_cnt[gi*STALL_CW +: STALL_CW] = cnt_reg;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule
